// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core.
// Contents: opcode/funct codes, FSM state and ALU operation enums, and
// helpers for sign extension, legality and R-type funct decode.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    sext16 = {{16{imm[15]}}, imm};
  endfunction

  // True for every opcode (and R-type funct) the core can execute.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_legal = 1'b1;
          default:                               is_legal = 1'b0;
        endcase
      end
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: is_legal = 1'b1;
      default:                                     is_legal = 1'b0;
    endcase
  endfunction

  function automatic alu_op_t funct_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  funct_to_alu = ALU_SUB;
      FN_AND:  funct_to_alu = ALU_AND;
      FN_OR:   funct_to_alu = ALU_OR;
      FN_SLT:  funct_to_alu = ALU_SLT;
      default: funct_to_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_core_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// Ports: clk, rst (async active-low, clears all registers), we/waddr/wdata
// write port, raddr_a/rdata_a and raddr_b/rdata_b read ports.
// Register 0 always reads as zero; writes to it are dropped.
module mips_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b
);

  logic [31:0] regs [32];

  // Register write on the clock edge; a same-cycle read sees the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core with one shared req/ready memory port.
// Ports: clk, rst (async active-low), clr (sync restart, registers kept);
// memory port mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata/mem_ready in;
// status pc_out, retire (one pulse per instruction), trap (sticky).
// All memory-port outputs are registers written by the FSM, so none of them
// depend combinationally on mem_ready.
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              retire,
  output logic              trap
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir, a, b, alu_out, mdr;

  logic [5:0]  opcode, fn;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_ext, pc32, jump_target, alu_b, alu_res, rf_a, rf_b, rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_we;
  alu_op_t     alu_op;
  logic [ADDR_W-1:0] exec_pc;

  assign opcode      = ir[31:26];
  assign rs          = ir[25:21];
  assign rt          = ir[20:16];
  assign rd          = ir[15:11];
  assign fn          = ir[5:0];
  assign imm_ext     = sext16(ir[15:0]);
  assign pc32        = 32'(pc);
  // Jump keeps the top nibble of the already-incremented PC.
  assign jump_target = {pc32[31:28], ir[25:0], 2'b00};
  assign pc_out      = pc;

  mips_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (rs),
    .rdata_a (rf_a),
    .raddr_b (rt),
    .rdata_b (rf_b)
  );

  // Inline ALU: R-type uses funct and B, everything else adds the immediate.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_ext;
    if (opcode == OP_RTYPE) begin
      alu_op = funct_to_alu(fn);
      alu_b  = b;
    end else begin
      alu_op = ALU_ADD;
      alu_b  = imm_ext;
    end
    case (alu_op)
      ALU_ADD: alu_res = a + alu_b;
      ALU_SUB: alu_res = a - alu_b;
      ALU_AND: alu_res = a & alu_b;
      ALU_OR:  alu_res = a | alu_b;
      ALU_SLT: alu_res = {31'd0, ($signed(a) < $signed(alu_b))};
      default: alu_res = a + alu_b;
    endcase
  end

  // PC chosen by a control-transfer instruction in EXEC.
  always_comb begin
    exec_pc = pc;
    case (opcode)
      OP_BEQ: if (a == b) exec_pc = alu_out[ADDR_W-1:0]; else exec_pc = pc;
      OP_BNE: if (a != b) exec_pc = alu_out[ADDR_W-1:0]; else exec_pc = pc;
      OP_J:   exec_pc = jump_target[ADDR_W-1:0];
      default: exec_pc = pc;
    endcase
  end

  // Register-file write port, active only in WB.
  always_comb begin
    rf_we    = (state == WB);
    rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
    rf_wdata = (opcode == OP_LW) ? mdr : alu_out;
  end

  // Main FSM with registered memory-port and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      ir        <= 32'd0;
      a         <= 32'd0;
      b         <= 32'd0;
      alu_out   <= 32'd0;
      mdr       <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= 32'd0;
      retire    <= 1'b0;
      trap      <= 1'b0;
    end else begin
      retire <= 1'b0;
      if (clr) begin
        // Restart drops any outstanding request; FETCH re-issues it next cycle.
        state    <= FETCH;
        pc       <= RESET_PC;
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        mem_addr <= RESET_PC;
        trap     <= 1'b0;
      end else begin
        case (state)
          BOOT: begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
          FETCH: begin
            if (!mem_req) begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc;
            end else if (mem_ready) begin
              ir      <= mem_rdata;
              pc      <= pc + PC_STEP;
              mem_req <= 1'b0;
              state   <= DECODE;
            end
          end
          DECODE: begin
            a       <= rf_a;
            b       <= rf_b;
            alu_out <= pc32 + (imm_ext << 2);
            if (is_legal(opcode, fn)) begin
              state <= EXEC;
            end else begin
              state <= TRAP;
              trap  <= 1'b1;
            end
          end
          EXEC: begin
            case (opcode)
              OP_LW, OP_SW: begin
                alu_out <= alu_res;
                if (alu_res[1:0] != 2'b00) begin
                  state <= TRAP;
                  trap  <= 1'b1;
                end else begin
                  state     <= MEM;
                  mem_req   <= 1'b1;
                  mem_we    <= (opcode == OP_SW);
                  mem_addr  <= alu_res[ADDR_W-1:0];
                  mem_wdata <= b;
                end
              end
              OP_BEQ, OP_BNE, OP_J: begin
                pc       <= exec_pc;
                mem_addr <= exec_pc;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                retire   <= 1'b1;
                state    <= FETCH;
              end
              default: begin
                alu_out <= alu_res;
                state   <= WB;
              end
            endcase
          end
          MEM: begin
            if (mem_ready) begin
              if (mem_we) begin
                retire   <= 1'b1;
                state    <= FETCH;
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= pc;
              end else begin
                mdr     <= mem_rdata;
                mem_req <= 1'b0;
                state   <= WB;
              end
            end
          end
          WB: begin
            retire   <= 1'b1;
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
          TRAP: begin
            mem_req <= 1'b0;
            trap    <= 1'b1;
          end
          default: begin
            state   <= TRAP;
            mem_req <= 1'b0;
            trap    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
Parametrised multi-cycle successor to the single-cycle MIPS top. One shared memory port with a req/ready handshake carries both instruction fetch and data access, so the core tolerates wait-state memories. A Moore FSM sequences FETCH/DECODE/EXEC/MEM/WB. New relative to the single-cycle core: wait states, bne, addi, alignment and illegal-instruction trap, retire pulse, and a configurable PC width and reset vector.

Parameters:
ADDR_W, 32, width of PC and memory address (range 8..32)
RESET_PC, 0, PC value after rst and after clr; must be a multiple of 4

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous restart: PC<=RESET_PC, FSM->FETCH, register file kept
mem_req  out  1  memory request, held stable until mem_ready
mem_we  out  1  1=write (sw), 0=read
mem_addr  out  ADDR_W  byte address, word aligned
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  completes current request; ignored while mem_req=0
pc_out  out  ADDR_W  current PC
retire  out  1  one-cycle pulse per completed instruction
trap  out  1  sticky: illegal opcode/funct or misaligned data address

Behaviour:
- Reset (rst=0): state=BOOT, PC=RESET_PC, IR/A/B/ALUOut/MDR=0, all 32 registers=0. All outputs 0 except pc_out=RESET_PC.
- BOOT: one cycle with mem_req=0, then FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. Stay until mem_ready=1. On ready: IR<=mem_rdata, PC<=PC+4 (wraps modulo 2^ADDR_W), go to DECODE.
- DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=PC+(sext(imm16)<<2), then EXEC. Illegal opcode or R-type funct goes to TRAP instead.
- Supported opcodes: R=0x00 (funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A signed), lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, j 0x02.
- EXEC by opcode:
  - R-type: ALUOut<=A op B, then WB.
  - addi: ALUOut<=A+sext, no overflow trap, then WB.
  - lw/sw: ALUOut<=A+sext. If the sum[1:0]!=0, go to TRAP; else MEM.
  - beq/bne: if the condition holds, PC<=ALUOut. retire=1, then FETCH.
  - j: PC<={PC[ADDR_W-1:28] (if ADDR_W>28), imm26, 2'b00} truncated to ADDR_W. retire=1, then FETCH.
- MEM: mem_req=1, mem_addr=ALUOut[ADDR_W-1:0], mem_we=(sw), mem_wdata=B. Wait for mem_ready.
  - lw: MDR<=mem_rdata, then WB.
  - sw: retire=1, then FETCH.
- WB: writes rf[rd] with ALUOut for R-type, or rf[rt] with ALUOut (addi) / MDR (lw). Writes to $0 are discarded. retire=1, then FETCH.
- Cycle counts with zero-wait memory (mem_ready same cycle as req), in total cycles per instruction: j/beq/bne 3, sw/R/addi 4, lw 5. Each wait state adds one cycle.
- TRAP: trap=1, mem_req=0, retire=0. Leaves only via clr or rst.
- clr has priority over every state transition.
  - clr during FETCH/MEM: mem_req drops the next cycle; a concurrent mem_ready is ignored; a pending sw is not completed by the core.
  - clr also clears trap.
- Register file: combinational read, write on the clock edge. A read of the register being written in the same cycle returns the old value; the FSM never needs forwarding because WB and DECODE never coincide.
- mem_req, mem_we, mem_addr and mem_wdata are decoded from state and holding registers only (Moore). None depend combinationally on mem_ready.

Decomposition:
- Package mips_pkg: opcode and funct localparams, state_t enum (BOOT, FETCH, DECODE, EXEC, MEM, WB, TRAP), alu_op_t enum, sign-extend function.
- Sub-module mips_regfile: 32x32 register file, 2 read ports, 1 write port, async active-low reset to 0, $0 hardwired to zero.
- ALU is inline in the core.

Test Plan:
- Reset/boot: RESET_PC=0x100, zero-wait memory; release rst -> mem_req=0 for one cycle, then mem_req=1 with mem_addr=0x100.
- Arithmetic: program addi $1,$0,5; addi $2,$0,-3; slt $3,$2,$1; sub $4,$1,$2 -> $3=1, $4=8. Four retire pulses, 16 cycles total.
- Wait states: sw $1,8($0) then lw $5,8($0) with mem_ready delayed 3 cycles each access -> $5=5. mem_addr, mem_we and mem_wdata stay stable while req is waiting. Each instruction takes 6 more cycles than zero-wait.
- Branches and jump: bne taken to PC+4+0x10, beq not taken, j 0x40 -> fetch addresses match exactly. 3 cycles each.
- Traps: fetched word 0xFC000000 -> trap=1 after DECODE, no further mem_req. Separately lw $1,2($0) -> trap with no memory access. Then clr=1 -> trap=0, fetch from RESET_PC, registers preserved.
- clr mid-fetch: assert clr while mem_req=1 and mem_ready=0 -> mem_req falls the next cycle, PC=RESET_PC, a late mem_ready is ignored.
